// File: rtl/aes_key_pkg.sv
// Shared encodings, lookups and FSM states for the AES key-expansion sequencer.
package aes_key_pkg;

  localparam logic [1:0] KEY_128 = 2'd0;
  localparam logic [1:0] KEY_192 = 2'd1;
  localparam logic [1:0] KEY_256 = 2'd2;
  localparam logic [1:0] KEY_BAD = 2'd3;

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD, CALC, WAIT, DONE
  } state_e;

  function automatic logic [5:0] nk_of(input logic [1:0] kl);
    unique case (1'b1)
      (kl == KEY_192): return 6'd6;
      (kl == KEY_256): return 6'd8;
      default:         return 6'd4;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(input logic [1:0] kl);
    unique case (1'b1)
      (kl == KEY_192): return 6'd52;
      (kl == KEY_256): return 6'd60;
      default:         return 6'd44;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_word_window.sv
// Eight-deep word history; taps w[i-1] and w[i-Nk] for the next schedule word.
module aes_key_word_window
  import aes_key_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] data,
  input  logic [1:0]  key_len,
  output logic [31:0] prev,
  output logic [31:0] origin
);

  logic [31:0] win [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) win[k] <= '0;
    end else if (push) begin
      win[0] <= data;
      for (int k = 1; k < 8; k++) win[k] <= win[k-1];
    end
  end

  assign prev = win[0];

  always_comb begin
    origin = win[3];
    unique case (1'b1)
      (key_len == KEY_192): origin = win[5];
      (key_len == KEY_256): origin = win[7];
      default:              origin = win[3];
    endcase
  end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES key-expansion sequencer around an external SBOX stage.
// Optional SBOX-wait timeout: define KEY_EXP_TIMEOUT_EN.
module aes_key_expand_ctrl
  import aes_key_pkg::*;
`ifdef KEY_EXP_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 15
)
`endif
(
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [1:0]  iKey_len,
  input  logic        iKey_valid,
  input  logic [31:0] iKey_word,
  output logic        oKey_ready,
  output logic        oSbox_rst_n,
  output logic        oSbox_valid,
  output logic        oSbox_special,
  output logic [31:0] oSbox_data,
  output logic [31:0] oSbox_origin,
  input  logic        iSbox_valid,
  input  logic [31:0] iSbox_data,
  output logic        oRk_valid,
  output logic [31:0] oRk_word,
  output logic [5:0]  oRk_index,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  state_e      state;
  logic [1:0]  klen;
  logic [5:0]  i;
  logic [2:0]  j;
  logic [5:0]  nk;
  logic [5:0]  nw;
  logic        sbox_turn;
  logic        last_j;
  logic        last_i;
  logic        push;
  logic [31:0] push_data;
  logic [31:0] prev;
  logic [31:0] origin;

`ifdef KEY_EXP_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic       err;
  logic [7:0] tcnt;
  assign oErr = err;
`else
  assign oErr = 1'b0;
`endif

  assign oKey_ready = (state == LOAD);

  always_comb begin
    nk        = nk_of(klen);
    nw        = nw_of(klen);
    sbox_turn = (j == 3'd0) || (nk == 6'd8 && j == 3'd4);
    last_j    = ({3'b000, j} == nk - 6'd1);
    last_i    = (i == nw - 6'd1);
    push      = 1'b0;
    push_data = '0;
    case (state)
      LOAD: begin
        push      = iKey_valid;
        push_data = iKey_word;
      end
      CALC: begin
        push      = !sbox_turn;
        push_data = prev ^ origin;
      end
      WAIT: begin
        push      = iSbox_valid;
        push_data = iSbox_data;
      end
      default: ;
    endcase
  end

  aes_key_word_window u_window (
    .clk     (iClk),
    .rst     (iRst),
    .push    (push),
    .data    (push_data),
    .key_len (klen),
    .prev    (prev),
    .origin  (origin)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state         <= IDLE;
      klen          <= KEY_128;
      i             <= '0;
      j             <= '0;
      oSbox_rst_n   <= 1'b1;
      oSbox_valid   <= 1'b0;
      oSbox_special <= 1'b0;
      oSbox_data    <= '0;
      oSbox_origin  <= '0;
      oRk_valid     <= 1'b0;
      oRk_word      <= '0;
      oRk_index     <= '0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
`ifdef KEY_EXP_TIMEOUT_EN
      err           <= 1'b0;
      tcnt          <= '0;
`endif
    end else begin
      oSbox_rst_n <= 1'b1;
      oSbox_valid <= 1'b0;
      oRk_valid   <= 1'b0;
      oDone       <= 1'b0;
      if (push) begin
        oRk_valid <= 1'b1;
        oRk_word  <= push_data;
        oRk_index <= i;
        i         <= i + 6'd1;
      end
      case (state)
        IDLE: begin
          if (iStart && iKey_len != KEY_BAD) begin
            klen        <= iKey_len;
            i           <= '0;
            j           <= '0;
            oBusy       <= 1'b1;
            oSbox_rst_n <= 1'b0;
`ifdef KEY_EXP_TIMEOUT_EN
            err         <= 1'b0;
`endif
            state       <= CLR;
          end
        end
        CLR: state <= LOAD;
        LOAD: begin
          if (push && i == nk - 6'd1) begin
            j     <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (sbox_turn) begin
            oSbox_valid   <= 1'b1;
            oSbox_special <= (j != 3'd0);
            oSbox_data    <= prev;
            oSbox_origin  <= origin;
`ifdef KEY_EXP_TIMEOUT_EN
            tcnt          <= '0;
`endif
            state         <= WAIT;
          end else begin
            j     <= last_j ? 3'd0 : j + 3'd1;
            state <= last_i ? DONE : CALC;
          end
        end
        WAIT: begin
          if (push) begin
            j     <= last_j ? 3'd0 : j + 3'd1;
            state <= last_i ? DONE : CALC;
          end
`ifdef KEY_EXP_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        DONE: begin
          oDone <= 1'b1;
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Self-checking bench: FIPS-197 key vectors, SBOX stage model, scoreboard queue.
module tb_aes_key_expand_ctrl;

  logic        clk = 1'b0;
  logic        iRst, iStart, iKey_valid;
  logic [1:0]  iKey_len;
  logic [31:0] iKey_word;
  logic        oKey_ready, oSbox_rst_n, oSbox_valid, oSbox_special;
  logic [31:0] oSbox_data, oSbox_origin;
  logic        iSbox_valid = 1'b0;
  logic [31:0] iSbox_data = '0;
  logic        oRk_valid;
  logic [31:0] oRk_word;
  logic [5:0]  oRk_index;
  logic        oBusy, oDone, oErr;

  always #5 clk = ~clk;

  aes_key_expand_ctrl dut (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iKey_len(iKey_len),
    .iKey_valid(iKey_valid), .iKey_word(iKey_word), .oKey_ready(oKey_ready),
    .oSbox_rst_n(oSbox_rst_n), .oSbox_valid(oSbox_valid),
    .oSbox_special(oSbox_special), .oSbox_data(oSbox_data),
    .oSbox_origin(oSbox_origin), .iSbox_valid(iSbox_valid),
    .iSbox_data(iSbox_data), .oRk_valid(oRk_valid), .oRk_word(oRk_word),
    .oRk_index(oRk_index), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  typedef struct packed {
    logic [1:0]        klen;
    logic [7:0][31:0]  key;
    logic [5:0]        nw;
    logic [3:0]        ns;
    logic [3:0]        nsp;
    logic [2:0][5:0]   idx;
    logic [2:0][31:0]  val;
  } vec_t;

  int n_cmp = 0, n_err = 0;
  int done_cnt, rk_cnt, n_issue, n_spec, clr_cnt;
  logic [7:0]  sbt [256];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  logic [37:0] sbq [$];
  logic        sbox_en = 1'b1;
  logic        pend_v = 1'b0;
  logic [31:0] pend_d = '0;
  logic [7:0]  rcon = 8'h01;
  vec_t        vt [3];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      s = 8'h63;
      for (int r = 0; r < 5; r++)
        s ^= (r == 0) ? inv : 8'((inv << r) | (inv >> (8 - r)));
      sbt[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic int nk_tb(input logic [1:0] kl);
    return (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
  endfunction

  function automatic vec_t mk(input logic [1:0] kl,
      input logic [31:0] k0, k1, k2, k3, k4, k5, k6, k7,
      input logic [5:0] nw, input logic [3:0] ns, nsp,
      input logic [5:0] i0, input logic [31:0] v0,
      input logic [5:0] i1, input logic [31:0] v1,
      input logic [5:0] i2, input logic [31:0] v2);
    vec_t r;
    r.klen = kl;
    r.key  = {k7, k6, k5, k4, k3, k2, k1, k0};
    r.nw = nw; r.ns = ns; r.nsp = nsp;
    r.idx = {i2, i1, i0};
    r.val = {v2, v1, v0};
    return r;
  endfunction

  // Reference schedule in textbook form, pushed to the scoreboard
  task automatic gen_model(input vec_t v);
    int nk = nk_tb(v.klen);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int k = 0; k < nk; k++) exp_w[k] = v.key[k];
    for (int k = nk; k < int'(v.nw); k++) begin
      t = exp_w[k-1];
      if (k % nk == 0) begin
        t  = subw(rotw(t)) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && k % nk == 4) begin
        t = subw(t);
      end
      exp_w[k] = exp_w[k-nk] ^ t;
    end
    for (int k = 0; k < int'(v.nw); k++) sbq.push_back({6'(k), exp_w[k]});
  endtask

  // SBOX stage model: one-cycle latency, rcon pointer cleared by oSbox_rst_n
  always @(negedge clk) begin
    iSbox_valid = pend_v;
    iSbox_data  = pend_d;
    pend_v      = 1'b0;
    if (!oSbox_rst_n) rcon = 8'h01;
    if (oSbox_valid) begin
      n_issue++;
      if (oSbox_special) n_spec++;
      if (sbox_en) begin
        pend_v = 1'b1;
        pend_d = oSbox_special ? subw(oSbox_data) ^ oSbox_origin
               : subw(rotw(oSbox_data)) ^ {rcon, 24'h0} ^ oSbox_origin;
      end
      if (!oSbox_special) rcon = xt(rcon);
    end
  end

  always @(negedge clk) begin
    logic [37:0] e;
    if (!oSbox_rst_n) clr_cnt++;
    if (oDone) done_cnt++;
    if (oRk_valid) begin
      rk_cnt++;
      got_w[oRk_index] = oRk_word;
      if (sbq.size() == 0) begin
        check("rk_unexpected", {oRk_index, oRk_word}, 38'h0);
      end else begin
        e = sbq.pop_front();
        check("rk_word", {oRk_index, oRk_word}, e);
      end
    end
  end

  task automatic chk_idle(input string nm);
    check(nm, {oKey_ready, oSbox_rst_n, oSbox_valid, oSbox_special,
               oRk_valid, oBusy, oDone, oErr, oRk_index}, {8'b0100_0000, 6'd0});
    check({nm, "_data"}, {oRk_word, oSbox_data | oSbox_origin}, 64'h0);
  endtask

  task automatic do_start(input vec_t v);
    int nk = nk_tb(v.klen);
    int k = 0;
    gen_model(v);
    done_cnt = 0; rk_cnt = 0; n_issue = 0; n_spec = 0; clr_cnt = 0;
    for (int m = 0; m < 64; m++) got_w[m] = '0;
    @(negedge clk); iStart = 1'b1; iKey_len = v.klen;
    @(negedge clk); iStart = 1'b0;
    check("busy_on", oBusy, 1);
    check("err_clr", oErr, 0);
    for (int c = 0; c < 20 && k < nk; c++) begin
      @(negedge clk);
      if (oKey_ready) begin
        iKey_valid = 1'b1; iKey_word = v.key[k]; k++;
      end else iKey_valid = 1'b0;
    end
    @(negedge clk); iKey_valid = 1'b0;
    check("key_load", k, nk);
  endtask

  task automatic wait_done(input vec_t v, input bit poke);
    for (int c = 0; c < 600; c++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
      if (poke && c == 30) begin
        iStart = 1'b1; iKey_len = 2'd2; iKey_valid = 1'b1; iKey_word = 32'hdeadbeef;
      end
      if (poke && c == 32) begin
        iStart = 1'b0; iKey_valid = 1'b0;
      end
    end
    check("done_seen", done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("rk_count", rk_cnt, v.nw);
    check("sb_empty", sbq.size(), 0);
    check("sbox_issues", n_issue, v.ns);
    check("sbox_special", n_spec, v.nsp);
    check("clr_pulse", clr_cnt, 1);
    check("busy_off", oBusy, 0);
    for (int m = 0; m < 3; m++) check("w_known", got_w[v.idx[m]], v.val[m]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    iRst = 1'b1; iStart = 1'b0; iKey_len = 2'd0; iKey_valid = 1'b0; iKey_word = '0;
    build_sbox();
    vt[0] = mk(2'd0, 32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
               0, 0, 0, 0, 6'd44, 4'd10, 4'd0,
               6'd4, 32'ha0fafe17, 6'd43, 32'hb6630ca6, 6'd0, 32'h2b7e1516);
    vt[1] = mk(2'd1, 32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
               32'h62f8ead2, 32'h522c6b7b, 0, 0, 6'd52, 4'd8, 4'd0,
               6'd6, 32'hfe0c91f7, 6'd51, 32'h01002202, 6'd5, 32'h522c6b7b);
    vt[2] = mk(2'd2, 32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
               32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4,
               6'd60, 4'd13, 4'd6,
               6'd8, 32'h9ba35411, 6'd12, 32'ha8b09c1a, 6'd59, 32'h706c631e);

    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    iRst = 1'b0;

    for (int n = 0; n < 3; n++) begin
      do_start(vt[n]);
      wait_done(vt[n], 1'b0);
    end

    // Start and stray key words during busy must be ignored; rerun repeats rcon
    do_start(vt[0]);
    wait_done(vt[0], 1'b1);
    do_start(vt[0]);
    wait_done(vt[0], 1'b0);

    // Reset while in CALC at i=20
    do_start(vt[0]);
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
        @(negedge clk);
        if (oRk_valid && oRk_index == 6'd19) hit = 1'b1;
      end
      check("reach_i20", hit, 1);
    end
    iRst = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset");
    iRst = 1'b0;
    sbq.delete();
    repeat (20) @(negedge clk);
    check("no_done_after_rst", done_cnt, 0);
    check("idle_after_rst", oBusy, 0);

    // Illegal key length is ignored
    clr_cnt = 0;
    @(negedge clk); iStart = 1'b1; iKey_len = 2'd3;
    @(negedge clk); iStart = 1'b0;
    repeat (3) @(negedge clk);
    check("bad_len_busy", {oBusy, oKey_ready}, 0);
    check("bad_len_clr", clr_cnt, 0);

`ifdef KEY_EXP_TIMEOUT_EN
    sbox_en = 1'b0;
    do_start(vt[0]);
    for (int c = 0; c < 100; c++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("to_done", done_cnt, 1);
    check("to_err", oErr, 1);
    check("to_words", rk_cnt, 4);
    sbq.delete();
    sbox_en = 1'b1;
`endif

    do_start(vt[2]);
    wait_done(vt[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
